// File: rtl/burst_line_pkg.sv
// burst_line_pkg
//   Shared types and constants for the burst RAM line controller.
//   - state_e   : controller state encoding
//   - CMD_READ  : ram_cmd value for a burst read
//   - CMD_WRITE : ram_cmd value for a burst write
package burst_line_pkg;

  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    RD_CMD  = 3'd2,
    RD_WAIT = 3'd3,
    WR_BEAT = 3'd4,
    RESP    = 3'd5,
    SETTLE  = 3'd6
  } state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_line_ctrl.sv
// burst_line_ctrl
//   Turns whole-line read/write requests from the cache into one burst
//   command on the RAM side. Write lines are split into consecutive data
//   beats; read beats are gathered back into a line and returned with a
//   single-cycle response. RAM initialization and busy periods are hidden
//   behind req_ready.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (accept on valid & ready)
//   req_write           : 1 = write line, 0 = read line
//   req_addr            : line address; low beat-index bits are ignored
//   req_wdata/req_wmask : write line and per-byte mask (1 = keep old byte)
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : last completed read line
//   ram_cmd/ram_cmd_en  : burst command and its one-cycle strobe
//   ram_addr            : burst start address
//   ram_wr_data/mask    : write beat and its byte mask
//   ram_rd_data/valid   : read beat and its strobe
//   ram_busy            : RAM initializing or operating
//
// state   | meaning
// --------+-------------------------------------------------------------
// INIT    | waiting for RAM initialization to finish
// IDLE    | ready for a request
// RD_CMD  | read command strobe on the RAM port
// RD_WAIT | collecting read beats into the line register
// WR_BEAT | driving write beats, command strobe with the first one
// RESP    | resp_valid pulse
// SETTLE  | waiting for the RAM to drop busy before the next request
module burst_line_ctrl
  import burst_line_pkg::*;
#(
  parameter int AddressBitWidth = 21,
  parameter int DataBitWidth    = 64,
  parameter int BurstDataCount  = 4,
  localparam int LineBitWidth   = DataBitWidth * BurstDataCount,
  localparam int BeatIdxWidth   = $clog2(BurstDataCount),
  localparam int BeatMaskWidth  = DataBitWidth / 8,
  localparam int LineMaskWidth  = LineBitWidth / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [AddressBitWidth-1:0] req_addr,
  input  logic [LineBitWidth-1:0]    req_wdata,
  input  logic [LineMaskWidth-1:0]   req_wmask,
  output logic                       resp_valid,
  output logic [LineBitWidth-1:0]    resp_rdata,
  output logic                       ram_cmd,
  output logic                       ram_cmd_en,
  output logic [AddressBitWidth-1:0] ram_addr,
  output logic [DataBitWidth-1:0]    ram_wr_data,
  output logic [BeatMaskWidth-1:0]   ram_data_mask,
  input  logic [DataBitWidth-1:0]    ram_rd_data,
  input  logic                       ram_rd_data_valid,
  input  logic                       ram_busy
);

  localparam logic [BeatIdxWidth-1:0]    LastBeat  = BeatIdxWidth'(BurstDataCount - 1);
  localparam logic [AddressBitWidth-1:0] AlignMask = ~AddressBitWidth'(BurstDataCount - 1);

  state_e                       state_q,        state_d;
  logic [BeatIdxWidth-1:0]      beat_cnt_q,     beat_cnt_d;
  logic [LineBitWidth-1:0]      line_q,         line_d;
  logic [LineMaskWidth-1:0]     mask_line_q,    mask_line_d;
  logic                         req_ready_q,    req_ready_d;
  logic                         resp_valid_q,   resp_valid_d;
  logic [LineBitWidth-1:0]      resp_rdata_q,   resp_rdata_d;
  logic                         ram_cmd_q,      ram_cmd_d;
  logic                         ram_cmd_en_q,   ram_cmd_en_d;
  logic [AddressBitWidth-1:0]   ram_addr_q,     ram_addr_d;
  logic [DataBitWidth-1:0]      ram_wr_data_q,  ram_wr_data_d;
  logic [BeatMaskWidth-1:0]     ram_data_mask_q, ram_data_mask_d;

  logic [BeatIdxWidth-1:0]      beat_nxt;
  logic                         last_beat;

  // Beat k of a line lives at bits [k*DataBitWidth +: DataBitWidth]; the
  // loops keep every part-select constant so the mux maps cleanly.
  function automatic logic [DataBitWidth-1:0] beat_of(
    input logic [LineBitWidth-1:0] line,
    input logic [BeatIdxWidth-1:0] idx
  );
    logic [DataBitWidth-1:0] r;
    r = '0;
    for (int k = 0; k < BurstDataCount; k++) begin
      if (idx == BeatIdxWidth'(k)) r = line[k*DataBitWidth +: DataBitWidth];
    end
    return r;
  endfunction

  function automatic logic [BeatMaskWidth-1:0] mask_of(
    input logic [LineMaskWidth-1:0] mline,
    input logic [BeatIdxWidth-1:0]  idx
  );
    logic [BeatMaskWidth-1:0] r;
    r = '0;
    for (int k = 0; k < BurstDataCount; k++) begin
      if (idx == BeatIdxWidth'(k)) r = mline[k*BeatMaskWidth +: BeatMaskWidth];
    end
    return r;
  endfunction

  function automatic logic [LineBitWidth-1:0] put_beat(
    input logic [LineBitWidth-1:0] line,
    input logic [BeatIdxWidth-1:0] idx,
    input logic [DataBitWidth-1:0] beat
  );
    logic [LineBitWidth-1:0] r;
    r = line;
    for (int k = 0; k < BurstDataCount; k++) begin
      if (idx == BeatIdxWidth'(k)) r[k*DataBitWidth +: DataBitWidth] = beat;
    end
    return r;
  endfunction

  always_comb begin
    state_d         = state_q;
    beat_cnt_d      = beat_cnt_q;
    line_d          = line_q;
    mask_line_d     = mask_line_q;
    req_ready_d     = 1'b0;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = resp_rdata_q;
    ram_cmd_d       = ram_cmd_q;
    ram_cmd_en_d    = 1'b0;
    ram_addr_d      = ram_addr_q;
    ram_wr_data_d   = '0;
    ram_data_mask_d = '0;
    beat_nxt        = beat_cnt_q + 1'b1;
    last_beat       = (beat_cnt_q == LastBeat);

    unique case (state_q)
      INIT: begin
        if (!ram_busy) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end
      end

      IDLE: begin
        if (req_valid) begin
          beat_cnt_d   = '0;
          ram_addr_d   = req_addr & AlignMask;
          ram_cmd_en_d = 1'b1;
          if (req_write) begin
            state_d         = WR_BEAT;
            ram_cmd_d       = CMD_WRITE;
            line_d          = req_wdata;
            mask_line_d     = req_wmask;
            // Beat 0 goes out alongside the command strobe.
            ram_wr_data_d   = req_wdata[DataBitWidth-1:0];
            ram_data_mask_d = req_wmask[BeatMaskWidth-1:0];
          end else begin
            state_d   = RD_CMD;
            ram_cmd_d = CMD_READ;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end

      RD_CMD: begin
        state_d = RD_WAIT;
      end

      RD_WAIT: begin
        if (ram_rd_data_valid) begin
          line_d     = put_beat(line_q, beat_cnt_q, ram_rd_data);
          beat_cnt_d = beat_nxt;
          if (last_beat) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = line_d;
          end
        end
      end

      WR_BEAT: begin
        // beat_cnt_q is the beat currently on the port; load the next one.
        beat_cnt_d = beat_nxt;
        if (last_beat) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          ram_wr_data_d   = beat_of(line_q, beat_nxt);
          ram_data_mask_d = mask_of(mask_line_q, beat_nxt);
        end
      end

      RESP: begin
        state_d = SETTLE;
      end

      // The RAM raises busy only after it has taken the strobe, so this
      // is the first state where busy reflects the finished burst.
      SETTLE: begin
        if (!ram_busy) begin
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= INIT;
      beat_cnt_q      <= '0;
      line_q          <= '0;
      mask_line_q     <= '0;
      req_ready_q     <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      ram_cmd_q       <= CMD_READ;
      ram_cmd_en_q    <= 1'b0;
      ram_addr_q      <= '0;
      ram_wr_data_q   <= '0;
      ram_data_mask_q <= '0;
    end else begin
      state_q         <= state_d;
      beat_cnt_q      <= beat_cnt_d;
      line_q          <= line_d;
      mask_line_q     <= mask_line_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      ram_cmd_q       <= ram_cmd_d;
      ram_cmd_en_q    <= ram_cmd_en_d;
      ram_addr_q      <= ram_addr_d;
      ram_wr_data_q   <= ram_wr_data_d;
      ram_data_mask_q <= ram_data_mask_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign ram_cmd       = ram_cmd_q;
  assign ram_cmd_en    = ram_cmd_en_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wr_data   = ram_wr_data_q;
  assign ram_data_mask = ram_data_mask_q;

endmodule

// File: tb/tb_burst_line_ctrl.sv
// tb_burst_line_ctrl
//   Bench for burst_line_ctrl with a small burst RAM model (64 words,
//   init delay 10, read delay 4) and a line-level reference memory.
module tb_burst_line_ctrl;

  localparam int AW = 21;
  localparam int DW = 64;
  localparam int N  = 4;
  localparam int LW = DW * N;
  localparam int MW = LW / 8;
  localparam int RD_DELAY   = 4;
  localparam int INIT_DELAY = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          resp_valid;
  logic [LW-1:0] resp_rdata;
  logic          ram_cmd;
  logic          ram_cmd_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic [7:0]    ram_data_mask;
  logic [DW-1:0] ram_rd_data;
  logic          ram_rd_data_valid;
  logic          ram_busy;

  always #5 clk = ~clk;

  burst_line_ctrl #(.AddressBitWidth(AW), .DataBitWidth(DW), .BurstDataCount(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_cmd(ram_cmd), .ram_cmd_en(ram_cmd_en), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_data_mask(ram_data_mask),
    .ram_rd_data(ram_rd_data), .ram_rd_data_valid(ram_rd_data_valid),
    .ram_busy(ram_busy)
  );

  function automatic logic [63:0] init_word(input int i);
    case (i)
      0: return 64'h3F5A2E14B7C6A980;
      1: return 64'h9D8E2F17AB4C3E6F;
      2: return 64'hA1C3F7E2D5B8A9C4;
      3: return 64'h7D4E9F2C1B6A3D8F;
      default: return {32'h5EED0000 + 32'(i), 32'hC0FFEE00 ^ 32'(i)};
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (!m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // ---------------- RAM model ----------------
  logic [63:0] mem [64];
  bit          loaded = 1'b0;
  int          init_cnt = 0;
  logic        rd_act = 1'b0, wr_act = 1'b0;
  int          rd_dly = 0;
  logic [5:0]  rd_base = '0, rd_beat = '0, wr_base = '0, wr_beat = '0;

  always @(posedge clk) begin
    if (rst) begin
      if (!loaded) begin
        for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        loaded <= 1'b1;
      end
      init_cnt          <= INIT_DELAY;
      rd_act            <= 1'b0;
      wr_act            <= 1'b0;
      ram_rd_data_valid <= 1'b0;
      ram_rd_data       <= '0;
      ram_busy          <= 1'b1;
    end else begin
      init_cnt          <= (init_cnt > 0) ? init_cnt - 1 : 0;
      ram_rd_data_valid <= 1'b0;
      if (ram_cmd_en && !ram_cmd) begin
        rd_act  <= 1'b1;
        rd_dly  <= RD_DELAY - 1;
        rd_beat <= '0;
        rd_base <= ram_addr[5:0];
      end else if (rd_act) begin
        if (rd_dly > 0) rd_dly <= rd_dly - 1;
        else begin
          ram_rd_data_valid <= 1'b1;
          ram_rd_data       <= mem[rd_base + rd_beat];
          rd_beat           <= rd_beat + 6'd1;
          if (rd_beat == 6'd3) rd_act <= 1'b0;
        end
      end
      if (ram_cmd_en && ram_cmd) begin
        mem[ram_addr[5:0]] <= merge(mem[ram_addr[5:0]], ram_wr_data, ram_data_mask);
        wr_act  <= 1'b1;
        wr_beat <= 6'd1;
        wr_base <= ram_addr[5:0];
      end else if (wr_act) begin
        mem[wr_base + wr_beat] <= merge(mem[wr_base + wr_beat], ram_wr_data, ram_data_mask);
        wr_beat <= wr_beat + 6'd1;
        if (wr_beat == 6'd3) wr_act <= 1'b0;
      end
      ram_busy <= (init_cnt > 0) || ram_cmd_en || rd_act || wr_act;
    end
  end

  // ---------------- reference + checking ----------------
  logic [63:0] ref_mem [64];
  logic [LW-1:0] last_line;
  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic logic [LW-1:0] ref_line(input int base);
    logic [LW-1:0] l;
    for (int k = 0; k < N; k++) l[k*DW +: DW] = ref_mem[(base + k) % 64];
    return l;
  endfunction

  task automatic ref_write(input int base, input logic [LW-1:0] wd, input logic [MW-1:0] wm);
    for (int k = 0; k < N; k++)
      ref_mem[base + k] = merge(ref_mem[base + k], wd[k*DW +: DW], wm[k*8 +: 8]);
  endtask

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One request end to end, with cycle-accurate checks relative to accept.
  task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wd, input logic [MW-1:0] wm,
                         input logic [LW-1:0] exp_line);
    int cyc, n_cmd, n_resp, resp_at, last_v;
    logic [AW-1:0] c_addr;
    logic [LW-1:0] rd;
    logic beats_ok;
    n_cmd = 0; n_resp = 0; resp_at = -1; last_v = -1; c_addr = '0; rd = '0; beats_ok = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wmask = wm;
    cyc = 0;
    while (!req_ready && cyc < 300) begin @(negedge clk); cyc++; end
    if (!req_ready) begin
      req_valid = 1'b0;
      check({tag, "_ready_timeout"}, 0, 1);
      return;
    end
    @(negedge clk);
    req_valid = 1'b0; req_wdata = ~wd; req_wmask = ~wm;
    for (int k = 1; k <= 40; k++) begin
      if (ram_cmd_en) begin
        n_cmd++; c_addr = ram_addr;
        if (ram_cmd !== wr) beats_ok = 1'b0;
      end
      if (wr && k <= N) begin
        if (ram_wr_data !== wd[(k-1)*DW +: DW] || ram_data_mask !== wm[(k-1)*8 +: 8])
          beats_ok = 1'b0;
        if (ram_cmd_en !== (k == 1)) beats_ok = 1'b0;
      end
      if (ram_rd_data_valid) last_v = k;
      if (resp_valid) begin n_resp++; resp_at = k; rd = resp_rdata; end
      if (k < 40) @(negedge clk);
    end
    check({tag, "_cmd_cnt"}, 256'(n_cmd), 256'd1);
    check({tag, "_cmd_addr"}, 256'(c_addr), 256'(addr & ~AW'(N - 1)));
    check({tag, "_resp_cnt"}, 256'(n_resp), 256'd1);
    check({tag, "_rdata"}, rd, exp_line);
    if (wr) begin
      check({tag, "_beats"}, 256'(beats_ok), 256'd1);
      check({tag, "_resp_at"}, 256'(resp_at), 256'(N + 1));
    end else begin
      check({tag, "_cmd_type"}, 256'(beats_ok), 256'd1);
      check({tag, "_resp_lat"}, 256'(resp_at), 256'(last_v + 1));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 256'(req_ready), 256'd0);
    check({tag, "_resp_valid"}, 256'(resp_valid), 256'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 256'd0);
    check({tag, "_cmd_en"}, 256'(ram_cmd_en), 256'd0);
    check({tag, "_cmd"}, 256'(ram_cmd), 256'd0);
    check({tag, "_addr"}, 256'(ram_addr), 256'd0);
    check({tag, "_wr_data"}, 256'(ram_wr_data), 256'd0);
    check({tag, "_mask"}, 256'(ram_data_mask), 256'd0);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wd;
    logic [MW-1:0] wm;
    logic [LW-1:0] exp;
  } vec_t;

  vec_t tbl [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, busy_cyc, n;
    logic [LW-1:0] line0, w1234, wmix, exp;
    logic [AW-1:0] a;
    logic [LW-1:0] wd;
    logic [MW-1:0] wm;
    logic wr;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    line0 = {64'h7D4E9F2C1B6A3D8F, 64'hA1C3F7E2D5B8A9C4, 64'h9D8E2F17AB4C3E6F, 64'h3F5A2E14B7C6A980};
    w1234 = {64'd4, 64'd3, 64'd2, 64'd1};
    wmix  = {64'd4, 64'd3, 64'hAAAAAAAA_00000002, 64'd1};

    tbl[0] = '{1'b0, 21'd0, '0, '0, line0};
    tbl[1] = '{1'b0, 21'd5, '0, '0, {init_word(7), init_word(6), init_word(5), init_word(4)}};
    tbl[2] = '{1'b1, 21'd8, w1234, 32'h0000_0000, {init_word(7), init_word(6), init_word(5), init_word(4)}};
    tbl[3] = '{1'b0, 21'd8, '0, '0, w1234};
    tbl[4] = '{1'b1, 21'd8, {64'd0, 64'd0, 64'hAAAAAAAA_BBBBBBBB, 64'd0}, 32'hFFFF_0FFF, w1234};
    tbl[5] = '{1'b0, 21'd10, '0, '0, wmix};

    // Reset with a read request already pending.
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    cyc = 0; busy_cyc = 0;
    while (!req_ready && cyc < 100) begin
      if (ram_busy) busy_cyc++;
      @(negedge clk); cyc++;
    end
    check("init_ready", 256'(req_ready), 256'd1);
    check("init_busy_low", 256'(ram_busy), 256'd0);
    check("init_waited", 256'(busy_cyc >= INIT_DELAY - 2), 256'd1);
    @(negedge clk);
    req_valid = 1'b0;
    check("init_cmd_en", 256'(ram_cmd_en), 256'd1);
    check("init_ready_low", 256'(req_ready), 256'd0);
    cyc = 0;
    while (!resp_valid && cyc < 40) begin @(negedge clk); cyc++; end
    check("init_rdata", resp_rdata, line0);
    @(negedge clk);
    check("init_resp_1cyc", 256'(resp_valid), 256'd0);
    last_line = line0;

    // Directed vectors from the line-level plan.
    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("v%0d", i), tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].wm, tbl[i].exp);
      if (tbl[i].wr) ref_write(int'(tbl[i].addr) & ~(N - 1), tbl[i].wd, tbl[i].wm);
      else last_line = tbl[i].exp;
    end

    // Reset while the read is waiting for beats.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 21'd16;
    cyc = 0;
    while (!req_ready && cyc < 100) begin @(negedge clk); cyc++; end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (resp_valid) n++;
      if (k == 2) check("midrst_init_ready", 256'(req_ready), 256'd0);
      @(negedge clk);
    end
    check("midrst_no_resp", 256'(n), 256'd0);
    run_txn("midrst_read", 1'b0, 21'd17, '0, '0, ref_line(16));
    last_line = ref_line(16);

    // Random traffic against the reference memory.
    for (int t = 0; t < 30; t++) begin
      wr = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 63));
      for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom;
      wm = $urandom;
      exp = wr ? last_line : ref_line(int'(a) & ~(N - 1));
      run_txn($sformatf("r%0d", t), wr, a, wd, wm, exp);
      if (wr) ref_write(int'(a) & ~(N - 1), wd, wm);
      else last_line = exp;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
